// File: rtl/game_pkg.sv
// Shared encodings and widths for the game controller.
// Optional record register is enabled by defining GAME_RECORD_EN.
package game_pkg;

    localparam int          LIVES_W = 2;
    localparam logic [11:0] BCD_MAX = 12'h999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Three-digit BCD adder that clamps to 999 on overflow.
// Operands are assumed to hold valid BCD digits.
module bcd_add3
    import game_pkg::*;
(
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    output logic [11:0] sum_o
);

    logic [4:0]  dsum;
    logic        carry;
    logic [11:0] raw;

    always_comb begin
        dsum  = '0;
        carry = 1'b0;
        raw   = '0;
        for (int i = 0; i < 3; i++) begin
            dsum = {1'b0, a_i[i*4 +: 4]} + {1'b0, b_i[i*4 +: 4]}
                 + {4'd0, carry};
            if (dsum > 5'd9) begin
                dsum  = dsum + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            raw[i*4 +: 4] = dsum[3:0];
        end
        sum_o = carry ? BCD_MAX : raw;
    end

endmodule

// File: rtl/game_controller.sv
// Game flow FSM: start, scoring, lives, hit pause, game over.
// Define GAME_RECORD_EN to keep a high-score register.
module game_controller
    import game_pkg::*;
#(
    parameter int          LIVES_INIT       = 3,
    parameter int          HIT_PAUSE_FRAMES = 60,
    parameter logic [11:0] SCORE_PER_KILL   = 12'h010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               frame_tick,
    input  logic               enemy_hit,
    input  logic               player_hit,
    input  logic               invaders_landed,
    input  logic               wave_cleared,
    output logic [1:0]         state,
    output logic               game_active,
    output logic               vivo_jogador,
    output logic [LIVES_W-1:0] lives,
    output logic [11:0]        score,
    output logic [11:0]        record,
    output logic               wave_restart
);

    localparam logic [7:0] PAUSE_LAST = 8'(HIT_PAUSE_FRAMES - 1);

    state_e               state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [11:0]          score_q, score_d;
    logic [7:0]           pause_q, pause_d;
    logic                 wave_q, wave_d;
    logic                 start_prev_q;
    logic                 active_q;
    logic                 vivo_q;
    logic                 start_pulse;
    logic [11:0]          score_sum;

    bcd_add3 u_add (
        .a_i   (score_q),
        .b_i   (SCORE_PER_KILL),
        .sum_o (score_sum)
    );

    assign start_pulse = btn_start & ~start_prev_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        pause_d = pause_q;
        wave_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_pulse) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    lives_d = LIVES_W'(LIVES_INIT);
                    wave_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (enemy_hit) score_d = score_sum;
                // Landing beats a simultaneous ship hit.
                if (invaders_landed) begin
                    state_d = ST_OVER;
                    lives_d = '0;
                end else if (player_hit) begin
                    lives_d = lives_q - LIVES_W'(1);
                    if (lives_q == LIVES_W'(1)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_HIT;
                        pause_d = '0;
                    end
                end else if (wave_cleared) begin
                    wave_d = 1'b1;
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (pause_q == PAUSE_LAST) begin
                        state_d = ST_PLAY;
                        pause_d = '0;
                    end else begin
                        pause_d = pause_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= '0;
            score_q      <= '0;
            pause_q      <= '0;
            wave_q       <= 1'b0;
            start_prev_q <= 1'b1;
            active_q     <= 1'b0;
            vivo_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            pause_q      <= pause_d;
            wave_q       <= wave_d;
            start_prev_q <= btn_start;
            active_q     <= (state_d == ST_PLAY);
            vivo_q       <= (state_d != ST_HIT) && (state_d != ST_OVER);
        end
    end

`ifdef GAME_RECORD_EN
    logic [11:0] record_q;

    // BCD digits order like binary, so a plain compare works.
    always_ff @(posedge clk) begin
        if (reset) begin
            record_q <= '0;
        end else if (state_q == ST_OVER && score_q > record_q) begin
            record_q <= score_q;
        end
    end

    assign record = record_q;
`else
    assign record = 12'h000;
`endif

    assign state        = state_q;
    assign game_active  = active_q;
    assign vivo_jogador = vivo_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign wave_restart = wave_q;

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 Parameter HIT_PAUSE_FRAMES, default 60, frames frozen after player is hit (1..255).
REQ-003 Parameter SCORE_PER_KILL, default 12'h010, BCD points per enemy kill.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_start  input  1  start button, level, active-high, already debounced.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 enemy_hit  input  1  one-cycle pulse: player shot destroyed an enemy.
REQ-009 player_hit  input  1  one-cycle pulse: enemy shot hit the ship.
REQ-010 invaders_landed  input  1  level: fleet reached ship row.
REQ-011 wave_cleared  input  1  one-cycle pulse: all enemies destroyed.
REQ-012 state  output  2  IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-013 game_active  output  1  high only in PLAY; gates ship, shots, fleet movement.
REQ-014 vivo_jogador  output  1  low in HIT and OVER, else high.
REQ-015 lives  output  2  remaining lives.
REQ-016 score  output  12  current score, 3-digit BCD.
REQ-017 record  output  12  high score, 3-digit BCD.
REQ-018 wave_restart  output  1  one-cycle pulse: fleet and shots reload.

Function
REQ-019 All outputs registered; every response appears the cycle after the causing input.
REQ-020 Start = rising edge of btn_start (internal registered previous value); held level never retriggers.
REQ-021 IDLE/OVER + start -> PLAY: score=0, lives=LIVES_INIT, wave_restart pulses.
REQ-022 PLAY + enemy_hit -> score += SCORE_PER_KILL, BCD per digit; saturates at 12'h999.
REQ-023 PLAY + player_hit -> lives-1; result 0 -> OVER, else -> HIT with pause counter cleared.
REQ-024 PLAY + invaders_landed -> OVER, lives=0; takes priority over player_hit in the same cycle.
REQ-025 Same-cycle enemy_hit and player_hit in PLAY: both score and life update applied.
REQ-026 PLAY + wave_cleared -> wave_restart pulse, remain PLAY; ignored if the same cycle leaves PLAY.
REQ-027 HIT: counts frame_tick; at HIT_PAUSE_FRAMES ticks -> PLAY, wave_restart not pulsed; game inputs and start ignored.
REQ-028 OVER entry: if score > record, record = score on the next cycle; start -> PLAY per REQ-021.
REQ-029 Inputs other than start ignored in IDLE and OVER.

Reset
REQ-030 reset: state=IDLE, score=0, lives=0, pause counter=0, wave_restart=0, start-edge register=1 (no start during held button).
REQ-031 reset clears record to 0; applies mid-game in any state with no residual pulse.

Configuration
REQ-032 Macro GAME_RECORD_EN: defined -> record register per REQ-028; undefined -> record constant 12'h000, no compare logic.

Structure
REQ-033 Package game_pkg holds state encodings, BCD_MAX=12'h999, lives width.
REQ-034 Sub-module bcd_add3: combinational 3-digit BCD saturating adder, instanced once.

Verification
REQ-035 reset, btn_start 0->1 -> next cycle state=1, lives=3, score=000, wave_restart one pulse.
REQ-036 PLAY, 5 enemy_hit pulses -> score=050; score 995 + hit -> 999, further hits stay 999.
REQ-037 player_hit with lives=3 -> lives=2, state=2; after 60 frame_tick -> state=1; hits during pause ignored.
REQ-038 lives=1, same-cycle player_hit+enemy_hit at score 040 -> state=3, lives=0, score=050, record=050 one cycle later.
REQ-039 invaders_landed+player_hit same cycle, lives=3 -> state=3, lives=0; btn_start held across reset -> stays IDLE.
REQ-040 Build without GAME_RECORD_EN, play to OVER at score 120 -> record=000.
